ram_sp: RTL and testbench



---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_addr_decode.sv | 20 ++
 rtl/ram_sp.sv | 59 +++++
 tb/tb_ram_sp.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared widths and types for the single-port word RAM.
package ram_pkg;

    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [WORD_W-1:0] word_t;

    // A one-word memory still needs a one-bit index vector.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_addr_decode.sv
// Byte address to word index decode, shared by the read and write paths.
module ram_addr_decode
    import ram_pkg::*;
#(
    parameter int MEM_SIZE = 128,
    parameter int IDX_W    = idx_width(MEM_SIZE)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              in_range
);

    // Low two address bits select a byte within the word and are ignored.
    logic unused_byte_sel;
    assign unused_byte_sel = ^addr[1:0];

    assign idx      = addr[IDX_W+1:2];
    assign in_range = ({2'b00, addr[ADDR_W-1:2]} < ADDR_W'(MEM_SIZE));

endmodule

// File: rtl/ram_sp.sv
// Single-port word RAM: registered write, combinational read, async clear.
// Define RAM_BYTE_WRITE_EN to add per-byte write enables on port be.
module ram_sp
    import ram_pkg::*;
#(
    parameter int MEM_SIZE = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      we,
    input  word_t                     data_in,
`ifdef RAM_BYTE_WRITE_EN
    input  logic [BYTES_PER_WORD-1:0] be,
`endif
    output word_t                     data_out
);

    localparam int IDX_W = idx_width(MEM_SIZE);

    word_t            mem_q [MEM_SIZE];
    word_t            rd_word;
    word_t            wr_word_d;
    logic [IDX_W-1:0] idx;
    logic             in_range;

    ram_addr_decode #(
        .MEM_SIZE (MEM_SIZE),
        .IDX_W    (IDX_W)
    ) u_decode (
        .addr     (addr),
        .idx      (idx),
        .in_range (in_range)
    );

    assign rd_word  = in_range ? mem_q[idx] : '0;
    assign data_out = rd_word;

`ifdef RAM_BYTE_WRITE_EN
    // Disabled lanes are written back with their current contents.
    always_comb begin
        wr_word_d = rd_word;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (be[k]) wr_word_d[8*k +: 8] = data_in[8*k +: 8];
        end
    end
`else
    assign wr_word_d = data_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
        end else if (we && in_range) begin
            mem_q[idx] <= wr_word_d;
        end
    end

endmodule

// File: tb/tb_ram_sp.sv
// Self-checking bench for ram_sp: directed cases plus randomized traffic vs an array model.
module tb_ram_sp;

    localparam int MEM_SIZE = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
`ifdef RAM_BYTE_WRITE_EN
    logic [3:0]  be = 4'hF;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] model [MEM_SIZE];

    ram_sp #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .data_in  (data_in),
`ifdef RAM_BYTE_WRITE_EN
        .be       (be),
`endif
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int unsigned w;
        w = a >> 2;
        return (w < MEM_SIZE) ? model[w] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MEM_SIZE; i++) model[i] = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: addr=%h got=%h expected=%h", name, addr, got, exp);
        end
    endtask

    // Advance one rising edge, committing the write the spec rules allow.
    task automatic tick();
        int unsigned w;
        @(posedge clk);
        w = addr >> 2;
        if (we && !rst && w < MEM_SIZE) begin
`ifdef RAM_BYTE_WRITE_EN
            for (int k = 0; k < 4; k++)
                if (be[k]) model[w][8*k +: 8] = data_in[8*k +: 8];
`else
            model[w] = data_in;
`endif
        end
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        addr = a; data_in = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) chk("cycle", data_out, model_rd(addr));
    end

    initial begin
        model_clear();
        tick();
        tick();
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        addr = 0;   #1 chk("rst_a0", data_out, 32'h0);
        addr = 4;   #1 chk("rst_a4", data_out, 32'h0);
        addr = 508; #1 chk("rst_a508", data_out, 32'h0);

        // Basic write then combinational read
        write(32'd0, 32'h12345678);
        #1 chk("basic", data_out, 32'h12345678);
        chk("basic_model", model_rd(0), 32'h12345678);

        // Same-address: old value before edge, new after
        addr = 0; data_in = 32'h0BADF00D; we = 1'b1;
        #1 chk("raw_before", data_out, 32'h12345678);
        tick(); we = 1'b0;
        chk("raw_after", data_out, 32'h0BADF00D);
        write(32'd0, 32'h12345678);

        // Word aliasing
        write(32'd8, 32'hDEADBEEF);
        for (int a = 8; a < 12; a++) begin
            addr = a; #1 chk("alias", data_out, 32'hDEADBEEF);
        end
        addr = 12; #1 chk("alias_next", data_out, 32'h0);

        // Bounds
        write(32'd512, 32'hAAAA5555);
        addr = 512; #1 chk("oob_read", data_out, 32'h0);
        addr = 0;   #1 chk("oob_no_wrap", data_out, 32'h12345678);
        addr = 32'hFFFF_FFFC; #1 chk("oob_top", data_out, 32'h0);
        write(32'd508, 32'hCAFEF00D);
        addr = 508; #1 chk("last_word", data_out, 32'hCAFEF00D);
        chk("last_model", model_rd(508), 32'hCAFEF00D);

`ifdef RAM_BYTE_WRITE_EN
        be = 4'hF;
        write(32'd16, 32'h11223344);
        be = 4'b0101;
        write(32'd16, 32'hAABBCCDD);
        addr = 16; #1 chk("byte_en", data_out, 32'h11BB33DD);
        chk("byte_model", model_rd(16), 32'h11BB33DD);
        be = 4'b0000;
        write(32'd16, 32'hFFFFFFFF);
        addr = 16; #1 chk("byte_none", data_out, 32'h11BB33DD);
        be = 4'hF;
`endif

        // Reset mid-operation
        write(32'd4, 32'h1);
        addr = 4; #1 chk("pre_rst", data_out, 32'h1);
        rst = 1'b1; model_clear();
        #1 chk("async_rst", data_out, 32'h0);
        write(32'd4, 32'h5);
        addr = 4; #1 chk("wr_in_rst", data_out, 32'h0);
        rst = 1'b0;
        #1 chk("after_rst", data_out, 32'h0);
        addr = 0; #1 chk("after_rst_a0", data_out, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) addr = $urandom();
            else addr = $urandom_range(0, 4 * MEM_SIZE + 63);
            we      = ($urandom_range(0, 2) != 0);
            data_in = $urandom();
`ifdef RAM_BYTE_WRITE_EN
            be      = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1; model_clear();
                #1 rst = 1'b0;
            end
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            addr = i * 4; #1 chk("sweep", data_out, model[i]);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
